// File: rtl/oled_defs_pkg.sv
// Shared definitions for the OLED digit writer: SSD1306-style command
// opcodes, the I2C ctrl-bit encodings and the writer FSM state encoding.
package oled_defs;

  // Page-addressing command opcodes; low bits carry the operand.
  localparam logic [7:0] OP_PAGE   = 8'hB0;
  localparam logic [7:0] OP_COL_LO = 8'h00;
  localparam logic [7:0] OP_COL_HI = 8'h10;

  // Byte-layer ctrl flag: command vs. GRAM data.
  localparam logic CTRL_CMD  = 1'b0;
  localparam logic CTRL_DATA = 1'b1;

  // Number of address command bytes that precede the glyph data.
  localparam int unsigned CMD_BYTES = 3;

  // Writer FSM state encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

endpackage

// File: rtl/oled_font_digit.sv
// Combinational 5-column digit ROM, column LSB = top pixel row.
// Ports:
//   digit      in  4  digit code; 10..15 render blank
//   col        in  3  glyph column 0..4; 5..7 render blank
//   font_byte_c out 8 column bitmap
module oled_font_digit (
  input  logic [3:0] digit,
  input  logic [2:0] col,
  output logic [7:0] font_byte_c
);

  logic [39:0] glyph_row;

  // Five columns per glyph, leftmost column in the top byte.
  always_comb begin
    glyph_row = 40'h00_00_00_00_00;
    case (digit)
      4'd0: glyph_row = 40'h3E_51_49_45_3E;
      4'd1: glyph_row = 40'h00_42_7F_40_00;
      4'd2: glyph_row = 40'h42_61_51_49_46;
      4'd3: glyph_row = 40'h21_41_45_4B_31;
      4'd4: glyph_row = 40'h18_14_12_7F_10;
      4'd5: glyph_row = 40'h27_45_45_45_39;
      4'd6: glyph_row = 40'h3C_4A_49_49_30;
      4'd7: glyph_row = 40'h01_71_09_05_03;
      4'd8: glyph_row = 40'h36_49_49_49_36;
      4'd9: glyph_row = 40'h06_49_49_29_1E;
      default: glyph_row = 40'h00_00_00_00_00;
    endcase
  end

  // Column select.
  always_comb begin
    font_byte_c = 8'h00;
    case (col)
      3'd0: font_byte_c = glyph_row[39:32];
      3'd1: font_byte_c = glyph_row[31:24];
      3'd2: font_byte_c = glyph_row[23:16];
      3'd3: font_byte_c = glyph_row[15:8];
      3'd4: font_byte_c = glyph_row[7:0];
      default: font_byte_c = 8'h00;
    endcase
  end

endmodule

// File: rtl/oled_digit_writer.sv
// Renders one digit glyph into OLED GRAM through a byte-level I2C layer:
// page command, two column commands, GLYPH_W font bytes, GAP_W blank bytes.
// Ports:
//   sys_clk, sys_rst        clock, synchronous active-high reset
//   req_valid/req_ready     request handshake (ready = idle)
//   req_page/col/digit      request payload, registered on acceptance
//   iic_exec/w_ctrl/w_data  byte transfer start pulse, ctrl flag and byte
//   iic_done                transfer-complete pulse from the byte layer
//   busy, done              request in flight, end-of-request pulse
module oled_digit_writer
  import oled_defs::*;
#(
  parameter int unsigned GLYPH_W = 5,
  parameter int unsigned GAP_W   = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_page,
  input  logic [6:0] req_col,
  input  logic [3:0] req_digit,
  output logic       iic_exec,
  output logic       iic_w_ctrl,
  output logic [7:0] iic_w_data,
  input  logic       iic_done,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] LAST_IDX = 4'(CMD_BYTES + GLYPH_W + GAP_W - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] idx_q,   idx_d;
  logic [2:0] page_q,  page_d;
  logic [6:0] col_q,   col_d;
  logic [3:0] digit_q, digit_d;
  logic       exec_q,  exec_d;
  logic       ctrl_q,  ctrl_d;
  logic [7:0] data_q,  data_d;
  logic       busy_q,  busy_d;
  logic       done_q,  done_d;
  logic       load_c;
  logic       byte_ctrl_c;
  logic [7:0] byte_data_c;
  logic [3:0] font_idx_c;
  logic [7:0] font_byte_c;

  // Next-state and handshake control; load_c marks a new byte being issued.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    page_d  = page_q;
    col_d   = col_q;
    digit_d = digit_q;
    exec_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          page_d  = req_page;
          col_d   = req_col;
          digit_d = req_digit;
          idx_d   = 4'd0;
          state_d = ST_ISSUE;
          exec_d  = 1'b1;
          busy_d  = 1'b1;
          load_c  = 1'b1;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (iic_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_ISSUE;
            exec_d  = 1'b1;
            load_c  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  oled_font_digit u_font (
    .digit       (digit_q),
    .col         (3'(font_idx_c)),
    .font_byte_c (font_byte_c)
  );

  // Byte for index idx_d; uses next-cycle page/col so the first command
  // byte is ready in the cycle right after acceptance.
  always_comb begin
    font_idx_c  = idx_d - 4'(CMD_BYTES);
    byte_ctrl_c = CTRL_DATA;
    byte_data_c = 8'h00;
    case (idx_d)
      4'd0: begin
        byte_ctrl_c = CTRL_CMD;
        byte_data_c = OP_PAGE | {5'b0, page_d};
      end
      4'd1: begin
        byte_ctrl_c = CTRL_CMD;
        byte_data_c = OP_COL_LO | {4'b0, col_d[3:0]};
      end
      4'd2: begin
        byte_ctrl_c = CTRL_CMD;
        byte_data_c = OP_COL_HI | {5'b0, col_d[6:4]};
      end
      default: begin
        if (32'(font_idx_c) < GLYPH_W) byte_data_c = font_byte_c;
      end
    endcase
  end

  // Byte outputs hold until the next byte is issued.
  always_comb begin
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (load_c) begin
      ctrl_d = byte_ctrl_c;
      data_d = byte_data_c;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      page_q  <= 3'd0;
      col_q   <= 7'd0;
      digit_q <= 4'd0;
      exec_q  <= 1'b0;
      ctrl_q  <= CTRL_CMD;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      page_q  <= page_d;
      col_q   <= col_d;
      digit_q <= digit_d;
      exec_q  <= exec_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign iic_exec   = exec_q;
  assign iic_w_ctrl = ctrl_q;
  assign iic_w_data = data_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_oled_digit_writer.sv
// Directed bench for oled_digit_writer with a byte-layer responder model.
module tb_oled_digit_writer;

  logic       clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_page = 3'd0;
  logic [6:0] req_col = 7'd0;
  logic [3:0] req_digit = 4'd0;
  logic       iic_exec;
  logic       iic_w_ctrl;
  logic [7:0] iic_w_data;
  logic       iic_done;
  logic       busy;
  logic       done;

  logic resp_done = 1'b0;
  logic spur_done = 1'b0;
  assign iic_done = resp_done | spur_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Responder state and logs
  int         resp_dly = 4;
  int         cnt = 0;
  logic [7:0] cur_byte = 8'h00;
  logic       cur_ctrl = 1'b0;
  int         stab_err = 0;
  int         n_log = 0;
  int         n_dn = 0;
  logic [7:0] log_byte [0:63];
  logic       log_ctrl [0:63];
  int         log_cyc  [0:63];
  int         dn_cyc   [0:63];

  oled_digit_writer #(.GLYPH_W(5), .GAP_W(1)) dut (
    .sys_clk    (clk),
    .sys_rst    (sys_rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_page   (req_page),
    .req_col    (req_col),
    .req_digit  (req_digit),
    .iic_exec   (iic_exec),
    .iic_w_ctrl (iic_w_ctrl),
    .iic_w_data (iic_w_data),
    .iic_done   (iic_done),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte layer: logs each exec, returns iic_done resp_dly cycles later.
  always @(negedge clk) begin
    if (sys_rst) begin
      resp_done = 1'b0;
      cnt = 0;
    end else begin
      if (resp_done) resp_done = 1'b0;
      if (cnt > 0) begin
        if (iic_w_data !== cur_byte || iic_w_ctrl !== cur_ctrl) stab_err++;
        cnt--;
        if (cnt == 0) begin
          resp_done = 1'b1;
          if (n_dn < 64) dn_cyc[n_dn] = cyc;
          n_dn++;
        end
      end
      if (iic_exec === 1'b1) begin
        if (n_log < 64) begin
          log_byte[n_log] = iic_w_data;
          log_ctrl[n_log] = iic_w_ctrl;
          log_cyc[n_log]  = cyc;
        end
        n_log++;
        cur_byte = iic_w_data;
        cur_ctrl = iic_w_ctrl;
        cnt = resp_dly;
      end
    end
  end

  task automatic clear_logs();
    n_log = 0;
    n_dn = 0;
    stab_err = 0;
  endtask

  task automatic send(input logic [2:0] p, input logic [6:0] c,
                      input logic [3:0] d, output int acc);
    acc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        acc = cyc;
        break;
      end
    end
    req_page = p; req_col = c; req_digit = d; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    if (acc < 0) begin
      total++; bad++;
      $display("FAIL send_ready: ready never high, required 1");
    end
  endtask

  task automatic wait_done(input string nm, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dcyc = cyc;
        break;
      end
    end
    total++;
    if (dcyc < 0) begin
      bad++;
      $display("FAIL %s_done_timeout: no done pulse within 400 cycles", nm);
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    total++; if (iic_exec !== 1'b0) begin bad++; $display("FAIL rst_exec: got %b want 0", iic_exec); end
    total++; if (iic_w_ctrl !== 1'b0) begin bad++; $display("FAIL rst_ctrl: got %b want 0", iic_w_ctrl); end
    total++; if (iic_w_data !== 8'h00) begin bad++; $display("FAIL rst_data: got %h want 00", iic_w_data); end
    sys_rst = 1'b0;
    clear_logs();
  endtask

  task automatic test_digit1();
    logic [7:0] exp [9] = '{8'hB2, 8'h05, 8'h12, 8'h00, 8'h42, 8'h7F, 8'h40, 8'h00, 8'h00};
    int acc, dc;
    resp_dly = 4;
    clear_logs();
    send(3'd2, 7'h25, 4'd1, acc);
    wait_done("d1", dc);
    total++; if (busy !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL d1_idle_at_done: busy=%b ready=%b want 0/1", busy, req_ready); end
    total++; if (n_log != 9) begin bad++; $display("FAIL d1_count: got %0d want 9", n_log); end
    for (int k = 0; k < 9; k++) begin
      total++;
      if (log_byte[k] !== exp[k] || log_ctrl[k] !== (k >= 3)) begin
        bad++; $display("FAIL d1_byte%0d: got %h/%b want %h/%b", k, log_byte[k], log_ctrl[k], exp[k], (k >= 3));
      end
    end
    total++; if (log_cyc[0] != acc + 1) begin bad++; $display("FAIL d1_first_exec: got cyc %0d want %0d", log_cyc[0], acc + 1); end
    total++; if (dc != dn_cyc[8] + 1) begin bad++; $display("FAIL d1_done_cycle: got %0d want %0d", dc, dn_cyc[8] + 1); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL d1_done_width: got %b want 0", done); end
    total++; if (stab_err != 0) begin bad++; $display("FAIL d1_stable: got %0d changes want 0", stab_err); end
  endtask

  task automatic test_digit0();
    logic [7:0] exp [9] = '{8'hB0, 8'h00, 8'h10, 8'h3E, 8'h51, 8'h49, 8'h45, 8'h3E, 8'h00};
    int acc, dc;
    resp_dly = 2;
    clear_logs();
    send(3'd0, 7'd0, 4'd0, acc);
    wait_done("d0", dc);
    for (int k = 0; k < 9; k++) begin
      total++;
      if (log_byte[k] !== exp[k] || log_ctrl[k] !== (k >= 3)) begin
        bad++; $display("FAIL d0_byte%0d: got %h/%b want %h/%b", k, log_byte[k], log_ctrl[k], exp[k], (k >= 3));
      end
    end
    for (int k = 1; k < 9; k++) begin
      total++;
      if (log_cyc[k] != dn_cyc[k-1] + 1) begin
        bad++; $display("FAIL d0_exec_gap%0d: got cyc %0d want %0d", k, log_cyc[k], dn_cyc[k-1] + 1);
      end
    end
    total++; if (stab_err != 0) begin bad++; $display("FAIL d0_stable: got %0d changes want 0", stab_err); end
  endtask

  task automatic test_blank_edge();
    logic [7:0] exp [9] = '{8'hB7, 8'h0F, 8'h17, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    int acc, dc;
    resp_dly = 1;
    clear_logs();
    send(3'd7, 7'd127, 4'd12, acc);
    wait_done("blank", dc);
    total++; if (n_log != 9) begin bad++; $display("FAIL blank_count: got %0d want 9", n_log); end
    for (int k = 0; k < 9; k++) begin
      total++;
      if (log_byte[k] !== exp[k] || log_ctrl[k] !== (k >= 3)) begin
        bad++; $display("FAIL blank_byte%0d: got %h/%b want %h/%b", k, log_byte[k], log_ctrl[k], exp[k], (k >= 3));
      end
    end
  endtask

  task automatic test_back_to_back();
    int dA, dc, got;
    resp_dly = 3;
    clear_logs();
    got = 0;
    for (int i = 0; i < 100 && got == 0; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) got = 1;
    end
    req_page = 3'd1; req_col = 7'h40; req_digit = 4'd3; req_valid = 1'b1;
    @(negedge clk);
    req_page = 3'd4; req_col = 7'h08; req_digit = 4'd7;
    dA = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin dA = cyc; break; end
    end
    total++; if (dA < 0 || req_ready !== 1'b1) begin bad++; $display("FAIL b2b_first_done: cyc %0d ready=%b want done with ready 1", dA, req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if (iic_exec !== 1'b1 || busy !== 1'b1 || iic_w_data !== 8'hB4 || iic_w_ctrl !== 1'b0) begin
      bad++; $display("FAIL b2b_second_exec: exec=%b busy=%b data=%h ctrl=%b want 1/1/b4/0", iic_exec, busy, iic_w_data, iic_w_ctrl);
    end
    wait_done("b2b", dc);
    total++; if (n_log != 18) begin bad++; $display("FAIL b2b_count: got %0d want 18", n_log); end
    total++;
    if (log_byte[0] !== 8'hB1 || log_byte[1] !== 8'h00 || log_byte[2] !== 8'h14 || log_byte[3] !== 8'h21) begin
      bad++; $display("FAIL b2b_reqA: got %h %h %h %h want b1 00 14 21", log_byte[0], log_byte[1], log_byte[2], log_byte[3]);
    end
    total++;
    if (log_byte[9] !== 8'hB4 || log_byte[10] !== 8'h08 || log_byte[11] !== 8'h10 || log_byte[12] !== 8'h01) begin
      bad++; $display("FAIL b2b_reqB: got %h %h %h %h want b4 08 10 01", log_byte[9], log_byte[10], log_byte[11], log_byte[12]);
    end
    total++; if (log_cyc[9] != dA + 1) begin bad++; $display("FAIL b2b_exec_cycle: got %0d want %0d", log_cyc[9], dA + 1); end
  endtask

  task automatic test_reset_mid();
    int acc, seen;
    resp_dly = 4;
    clear_logs();
    send(3'd5, 7'd3, 4'd8, acc);
    for (int i = 0; i < 200 && n_log < 4; i++) @(negedge clk);
    sys_rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (iic_exec !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || iic_w_data !== 8'h00 || iic_w_ctrl !== 1'b0) begin
      bad++; $display("FAIL mid_rst_outputs: exec=%b busy=%b done=%b data=%h ctrl=%b want all 0", iic_exec, busy, done, iic_w_data, iic_w_ctrl);
    end
    sys_rst = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready: got %b want 1", req_ready); end
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (iic_exec === 1'b1 || done === 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL mid_rst_quiet: got %0d exec/done cycles want 0", seen); end
    total++; if (n_log != 4) begin bad++; $display("FAIL mid_rst_count: got %0d execs want 4", n_log); end
  endtask

  task automatic test_spurious();
    logic [7:0] exp [9] = '{8'hB3, 8'h0A, 8'h10, 8'h00, 8'h42, 8'h7F, 8'h40, 8'h00, 8'h00};
    int acc, dc, seen;
    clear_logs();
    @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (iic_exec === 1'b1 || req_ready !== 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL spur_idle: got %0d bad cycles want 0", seen); end
    resp_dly = 3;
    send(3'd3, 7'd10, 4'd1, acc);
    for (int i = 0; i < 6; i++) begin
      req_valid = (i % 2 == 0);
      req_page = 3'd6; req_col = 7'd99; req_digit = 4'd0;
      @(negedge clk);
    end
    req_valid = 1'b0;
    wait_done("spur", dc);
    total++; if (n_log != 9) begin bad++; $display("FAIL spur_count: got %0d want 9", n_log); end
    for (int k = 0; k < 9; k++) begin
      total++;
      if (log_byte[k] !== exp[k] || log_ctrl[k] !== (k >= 3)) begin
        bad++; $display("FAIL spur_byte%0d: got %h/%b want %h/%b", k, log_byte[k], log_ctrl[k], exp[k], (k >= 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_digit1();
    test_digit0();
    test_blank_edge();
    test_back_to_back();
    test_spurious();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
